// File: rtl/chess_pkg.sv
// Shared move-word layout, invalid-word constant and piece codes.
package chess_pkg;
  localparam int MOVE_W_STD = 19;
  localparam int SQ_W       = 6;
  // Field offsets within a MOVE_W_STD word (MSB first).
  localparam int INV_BIT = 18;
  localparam int PROMO   = 17;
  localparam int PAWN    = 16;
  localparam int PAWN2   = 15;
  localparam int EP      = 14;
  localparam int CASTLE  = 13;
  localparam int CAPT    = 12;
  localparam int FROM    = 6;
  localparam int TO      = 0;

  localparam logic [MOVE_W_STD-1:0] INVALID_MOVE = 19'h40000;

  typedef enum logic [2:0] {
    PC_NONE, PC_PAWN, PC_KNIGHT, PC_BISHOP, PC_ROOK, PC_QUEEN, PC_KING
  } piece_e;
endpackage

// File: rtl/move_compactor.sv
// Squeezes the valid lanes of a write group to slots 0..nvalid-1,
// highest lane first.
module move_compactor
  import chess_pkg::*;
#(
  parameter int MOVE_W = 19,
  parameter int LANES  = 8,
  parameter int NV_W   = $clog2(LANES+1)
) (
  input  logic [LANES*MOVE_W-1:0]          wr_data,
  output logic [LANES-1:0][MOVE_W-1:0]     packed_moves,
  output logic [NV_W-1:0]                  nvalid
);
  localparam logic [MOVE_W-1:0] INV_W = {1'b1, {(MOVE_W-1){1'b0}}};

  logic [LANES-1:0]           valid;
  logic [LANES-1:0][NV_W-1:0] slot;

  // Prefix count: a lane's slot is the number of valid lanes above it.
  always_comb begin
    logic [NV_W-1:0] acc;
    acc   = '0;
    valid = '0;
    slot  = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      valid[l] = ~wr_data[l*MOVE_W + MOVE_W-1];
      slot[l]  = acc;
      acc      = acc + NV_W'(valid[l]);
    end
    nvalid = acc;
  end

  // Route each valid lane to its slot; unused slots hold the invalid word.
  always_comb begin
    for (int s = 0; s < LANES; s++) begin
      packed_moves[s] = INV_W;
      for (int l = 0; l < LANES; l++)
        if (valid[l] && slot[l] == NV_W'(s))
          packed_moves[s] = wr_data[l*MOVE_W +: MOVE_W];
    end
  end
endmodule

// File: rtl/move_list_fifo.sv
// Move FIFO: compacts a lane group of moves, admits it whole or not at all,
// and presents the head move show-ahead to the collector.
module move_list_fifo
  import chess_pkg::*;
#(
  parameter int MOVE_W = 19,
  parameter int LANES  = 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [LANES*MOVE_W-1:0] wr_data,
  input  logic                    rd_en,
  output logic [MOVE_W-1:0]       rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NV_W  = $clog2(LANES+1);
  localparam logic [MOVE_W-1:0] INV_W = {1'b1, {(MOVE_W-1){1'b0}}};

  logic [MOVE_W-1:0]              mem [DEPTH];
  logic [PTR_W-1:0]               wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]               count_nxt, free;
  logic                           ovf_nxt, unf_nxt;
  logic [LANES-1:0][MOVE_W-1:0]   packed_moves;
  logic [NV_W-1:0]                nvalid;
  logic                           accept, drop, pop, bad_pop;

  move_compactor #(.MOVE_W(MOVE_W), .LANES(LANES), .NV_W(NV_W)) u_cmp (
    .wr_data      (wr_data),
    .packed_moves (packed_moves),
    .nvalid       (nvalid)
  );

  // Admission uses free space before any same-cycle pop; clear wins over everything.
  always_comb begin
    free       = CNT_W'(DEPTH) - count;
    accept     = !clear && wr_en && (nvalid != '0) && (CNT_W'(nvalid) <= free);
    drop       = !clear && wr_en && (CNT_W'(nvalid) > free);
    pop        = !clear && rd_en && !empty;
    bad_pop    = !clear && rd_en && empty;
    wr_ptr_nxt = accept ? wr_ptr + PTR_W'(nvalid) : wr_ptr;
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count + (accept ? CNT_W'(nvalid) : '0) - (pop ? CNT_W'(1) : '0);
    ovf_nxt    = overflow | drop;
    unf_nxt    = underflow | bad_pop;
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
      unf_nxt    = 1'b0;
    end
  end

  // Pointers, count and flags; flags come from the next-state count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= ((CNT_W'(DEPTH) - count_nxt) < CNT_W'(LANES));
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  // Storage: accepted slots land at consecutive addresses from wr_ptr, wrapping.
  always_ff @(posedge clk) begin
    for (int s = 0; s < LANES; s++)
      if (accept && (s < int'(nvalid)))
        mem[wr_ptr + PTR_W'(s)] <= packed_moves[s];
  end

  // Show-ahead head; the invalid word when nothing is stored.
  assign rd_data = empty ? INV_W : mem[rd_ptr];
endmodule
